video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Parametrised, runtime-reprogrammable raster timing generator for the video output path. Successor to the fixed per-field timing generator.
- Adds a pixel clock-enable, a shadowed timing register set applied only at frame boundaries, programmable sync polarity, a line-match interrupt and a frame counter.
- Drives scaler/OSD timing and the HDMI/VGA sync outputs. All outputs are registered.

Parameters:
- X_BITS, 12, width of all horizontal timing values and x/h_count.
- Y_BITS, 12, width of all vertical timing values and v_count.
- FRAME_BITS, 8, width of the frame counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; counters advance only when high
- cfg_load  in  1  strobe: capture cfg_* into pending shadow
- cfg_h_total/h_sync/h_bp/h_fp  in  X_BITS each  horizontal timing
- cfg_v_total/v_sync/v_bp/v_fp  in  Y_BITS each  vertical timing (field 0)
- cfg_interlaced  in  1  interlace mode
- cfg_hs_neg, cfg_vs_neg  in  1 each  sync polarity (1 = active-low)
- cfg_irq_line  in  Y_BITS  line-match compare value
- cfg_busy  out  1  pending config not yet applied
- cfg_applied  out  1  one-cycle pulse when pending config becomes active
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected
- hs, vs  out  1 each  syncs, polarity applied
- hde, vde, de  out  1 each  active-region flags; de = hde & vde
- x  out  X_BITS  active pixel column
- y  out  Y_BITS+1  active line; {line, field} when interlaced
- field  out  1  current field
- frame_cnt  out  FRAME_BITS  completed-frame counter, wraps
- line_irq  out  1  one-cycle pulse at h_count 0 of line cfg_irq_line

Behaviour:
- Reset:
  - Active config loads directly from cfg_* without validation.
  - Counters, field and frame_cnt go to 0. Pending is cleared.
  - hs = cfg_hs_neg, vs = cfg_vs_neg (inactive levels).
  - hde, vde, de, x, y, cfg_busy, cfg_applied, cfg_err and line_irq are all 0.
- Counting:
  - On a ce_pix cycle, h_count runs 0..h_total-1 and wraps to 0.
  - At wrap, v_count increments and wraps after the field's last line.
  - Field 0 has v_total lines. Field 1 has v_total+1 lines (interlaced only).
  - Progressive mode keeps field at 0. Interlaced mode toggles field at each field end.
- Outputs:
  - Outputs update one clk after a ce_pix cycle and hold otherwise (latency 1).
  - hs active while h_count < h_sync.
  - hde active for h_sync+h_bp <= h_count <= h_total-h_fp-1.
  - vde uses the same rule with the field's v_total.
  - x = h_count-(h_sync+h_bp), modulo 2^X_BITS. y uses the same rule vertically.
- vsync:
  - Asserts at v_count 0 and deasserts at v_count v_sync.
  - Transitions happen at h_count 0 in field 0 and at h_count h_total>>1 in field 1 (half-line offset).
- Frame end:
  - Frame end is the ce_pix cycle at the last pixel of the last line: any field when progressive, field 1 when interlaced.
  - At frame end frame_cnt increments (wrapping at 2^FRAME_BITS).
  - If pending is set, the shadow becomes active for the next pixel, cfg_applied pulses and cfg_busy clears in the same cycle.
- cfg_load validation:
  - Rejected (cfg_err pulse, pending unchanged) if h_total<4, v_total<2, h_sync+h_bp+h_fp>=h_total, or v_sync+v_bp+v_fp>=v_total.
  - Otherwise the shadow is overwritten (last-write-wins) and cfg_busy is set next clk.
- Simultaneous events: cfg_load on the same cycle as frame-end apply → the old pending is applied and the new load stays pending (cfg_busy remains 1).
- line_irq: pulses for exactly one clk when v_count==cfg_irq_line (active config) and h_count==0 on a ce_pix cycle. A compare value outside the range never fires.
- ce_pix held low: complete freeze, no pulses generated.
- Reset mid-frame: immediate restart at (0,0); pending is lost.

Decomposition:
- Shared package video_timing_pkg holds:
  - a packed timing-config struct (h/v fields, interlaced, polarities, irq_line);
  - a validation function;
  - localparams for minimum totals.
- Natural sub-module: vtg_cfg_shadow, which handles load, validate, pending/busy, apply-on-frame-end and the applied/err pulses. The counter/decode logic stays in the top level.

Test Plan:
- Timing check:
  - Stimulus: ce_pix=1, h 10/2/2/2, v 6/1/1/1, progressive.
  - Required: hs high at h_count 0-1 of each line; hde high for h_count 4..7 with x 0..3; vde on lines 2..4; de count per frame = 12; frame_cnt increments every 60 clks.
- Interlace check:
  - Stimulus: same config with cfg_interlaced=1.
  - Required: field 1 has 7 lines; in field 1 vs rises at h_count 5; y LSB = field; frame_cnt increments every 130 clks.
- Shadow apply:
  - Stimulus: cfg_load with h_total=12 mid-frame.
  - Required: cfg_busy=1 until frame end; line period stays 10 until then; cfg_applied pulses once; the next line period is 12.
- Invalid load:
  - Stimulus: cfg_load with h_sync+h_bp+h_fp=10, h_total=10.
  - Required: cfg_err pulse; cfg_busy stays 0; timing unchanged.
- Clock-enable and interrupt:
  - Stimulus: ce_pix toggled 1-of-3, cfg_irq_line=3.
  - Required: outputs change only the clk after a ce_pix cycle; line_irq is a one-clk pulse once per frame; cfg_hs_neg=1 inverts hs.
- Collision and reset:
  - Stimulus: cfg_load on the frame-end cycle with pending set, then reset mid-line.
  - Required: first config applied, cfg_busy remains 1; after reset all counters and outputs return to reset values and pending is cleared.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing config type, limits and validation for the raster generator
package video_timing_pkg;

    localparam int T_BITS = 16;
    localparam logic [T_BITS-1:0] MIN_H_TOTAL = 16'd4;
    localparam logic [T_BITS-1:0] MIN_V_TOTAL = 16'd2;

    typedef struct packed {
        logic [T_BITS-1:0] h_total, h_sync, h_bp, h_fp;
        logic [T_BITS-1:0] v_total, v_sync, v_bp, v_fp;
        logic              interlaced, hs_neg, vs_neg;
        logic [T_BITS-1:0] irq_line;
    } timing_cfg_t;

    function automatic logic cfg_valid(input timing_cfg_t c);
        logic [T_BITS+1:0] h_sum;
        logic [T_BITS+1:0] v_sum;
        h_sum = {2'b00, c.h_sync} + {2'b00, c.h_bp} + {2'b00, c.h_fp};
        v_sum = {2'b00, c.v_sync} + {2'b00, c.v_bp} + {2'b00, c.v_fp};
        return (c.h_total >= MIN_H_TOTAL) && (c.v_total >= MIN_V_TOTAL) &&
               (h_sum < {2'b00, c.h_total}) && (v_sum < {2'b00, c.v_total});
    endfunction

endpackage

// File: rtl/vtg_cfg_shadow.sv
// vtg_cfg_shadow: validates config loads, holds them pending and applies them at frame end
module vtg_cfg_shadow
    import video_timing_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  timing_cfg_t cfg,
    input  logic        frame_end,
    output timing_cfg_t active,
    output logic        busy,
    output logic        applied,
    output logic        err
);

    timing_cfg_t shadow;
    logic        ok;

    assign ok = cfg_valid(cfg);

    // apply reads the old shadow, so a load on the apply cycle stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= cfg;
            shadow  <= cfg;
            busy    <= 1'b0;
            applied <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (frame_end && busy) active <= shadow;
            if (load && ok) shadow <= cfg;
            busy    <= (load && ok) || (busy && !frame_end);
            applied <= frame_end && busy;
            err     <= load && !ok;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: reprogrammable raster timing generator with shadowed config and line interrupt
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic                  cfg_load,
    input  logic [X_BITS-1:0]     cfg_h_total,
    input  logic [X_BITS-1:0]     cfg_h_sync,
    input  logic [X_BITS-1:0]     cfg_h_bp,
    input  logic [X_BITS-1:0]     cfg_h_fp,
    input  logic [Y_BITS-1:0]     cfg_v_total,
    input  logic [Y_BITS-1:0]     cfg_v_sync,
    input  logic [Y_BITS-1:0]     cfg_v_bp,
    input  logic [Y_BITS-1:0]     cfg_v_fp,
    input  logic                  cfg_interlaced,
    input  logic                  cfg_hs_neg,
    input  logic                  cfg_vs_neg,
    input  logic [Y_BITS-1:0]     cfg_irq_line,
    output logic                  cfg_busy,
    output logic                  cfg_applied,
    output logic                  cfg_err,
    output logic                  hs,
    output logic                  vs,
    output logic                  hde,
    output logic                  vde,
    output logic                  de,
    output logic [X_BITS-1:0]     x,
    output logic [Y_BITS:0]       y,
    output logic                  field,
    output logic [FRAME_BITS-1:0] frame_cnt,
    output logic                  line_irq
);

    timing_cfg_t       cfg, act;
    logic [X_BITS-1:0] h_count;
    logic [Y_BITS-1:0] v_count, line;
    logic              fld, vs_on;
    logic [T_BITS-1:0] hc, vc, v_lines, h_start, h_end, v_start, v_end, vs_pos;
    logic              last_pix, last_line, field_end, frame_end, vs_now, hde_n, vde_n;

    assign cfg = '{
        h_total:    T_BITS'(cfg_h_total),
        h_sync:     T_BITS'(cfg_h_sync),
        h_bp:       T_BITS'(cfg_h_bp),
        h_fp:       T_BITS'(cfg_h_fp),
        v_total:    T_BITS'(cfg_v_total),
        v_sync:     T_BITS'(cfg_v_sync),
        v_bp:       T_BITS'(cfg_v_bp),
        v_fp:       T_BITS'(cfg_v_fp),
        interlaced: cfg_interlaced,
        hs_neg:     cfg_hs_neg,
        vs_neg:     cfg_vs_neg,
        irq_line:   T_BITS'(cfg_irq_line)
    };

    vtg_cfg_shadow u_shadow (
        .clk       (clk),
        .reset     (reset),
        .load      (cfg_load),
        .cfg       (cfg),
        .frame_end (frame_end),
        .active    (act),
        .busy      (cfg_busy),
        .applied   (cfg_applied),
        .err       (cfg_err)
    );

    // decode of the pixel at the current counter position; field 1 carries one extra line
    always_comb begin
        hc        = T_BITS'(h_count);
        vc        = T_BITS'(v_count);
        v_lines   = act.v_total + T_BITS'(fld);
        h_start   = act.h_sync + act.h_bp;
        h_end     = act.h_total - act.h_fp - 1'b1;
        v_start   = act.v_sync + act.v_bp;
        v_end     = v_lines - act.v_fp - 1'b1;
        vs_pos    = fld ? (act.h_total >> 1) : '0;
        last_pix  = hc == act.h_total - 1'b1;
        last_line = vc == v_lines - 1'b1;
        field_end = ce_pix && last_pix && last_line;
        frame_end = field_end && (!act.interlaced || fld);
        vs_now    = (hc == vs_pos) ? (vc < act.v_sync) : vs_on;
        hde_n     = hc >= h_start && hc <= h_end;
        vde_n     = vc >= v_start && vc <= v_end;
        line      = Y_BITS'(vc - v_start);
    end

    // raster counters and registered outputs, all frozen while ce_pix is low
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count   <= '0;
            v_count   <= '0;
            fld       <= 1'b0;
            vs_on     <= 1'b0;
            frame_cnt <= '0;
            hs        <= cfg_hs_neg;
            vs        <= cfg_vs_neg;
            hde       <= 1'b0;
            vde       <= 1'b0;
            de        <= 1'b0;
            x         <= '0;
            y         <= '0;
            field     <= 1'b0;
            line_irq  <= 1'b0;
        end else begin
            line_irq <= ce_pix && hc == '0 && vc == act.irq_line;
            if (ce_pix) begin
                h_count <= last_pix ? '0 : h_count + 1'b1;
                if (last_pix) v_count <= last_line ? '0 : v_count + 1'b1;
                if (field_end) fld <= act.interlaced & ~fld;
                if (frame_end) frame_cnt <= frame_cnt + 1'b1;
                vs_on <= vs_now;
                hs    <= (hc < act.h_sync) ^ act.hs_neg;
                vs    <= vs_now ^ act.vs_neg;
                hde   <= hde_n;
                vde   <= vde_n;
                de    <= hde_n & vde_n;
                x     <= X_BITS'(hc - h_start);
                y     <= act.interlaced ? {line, fld} : {1'b0, line};
                field <= fld;
            end
        end
    end

endmodule
